// File: rtl/sort_arbiter.sv
// sort_arbiter: shares one fixed-latency pipelined sorting network between
// REQ_AMOUNT requesters. Round-robin grant, requester ID carried in a tag line
// that runs alongside the network, results buffered in a credit-protected
// first-word-fall-through FIFO and returned as a valid/ready stream.
// Optional feature: define SORT_ARBITER_CHECK_EN to build the tag/inflight
// consistency checker that drives the sticky err_o flag (tied 0 otherwise).
module sort_arbiter #(
  parameter int NUMBER_WIDTH   = 10,
  parameter int NUMBERS_AMOUNT = 10,
  parameter int REQ_AMOUNT     = 4,
  parameter int NET_LATENCY    = 9,
  parameter int FIFO_DEPTH     = 16,
  localparam int ID_WIDTH      = $clog2(REQ_AMOUNT)
) (
  input  logic                                                     clk_i,
  input  logic                                                     rst_n_i,
  input  logic [REQ_AMOUNT-1:0][NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] req_data_i,
  input  logic [REQ_AMOUNT-1:0]                                    req_valid_i,
  output logic [REQ_AMOUNT-1:0]                                    req_ready_o,
  output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]              net_data_o,
  output logic                                                     net_valid_o,
  input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]              net_data_i,
  input  logic                                                     net_valid_i,
  output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]              res_data_o,
  output logic [ID_WIDTH-1:0]                                      res_id_o,
  output logic                                                     res_valid_o,
  input  logic                                                     res_ready_i,
  output logic                                                     err_o
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  typedef logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] vec_t;

  logic [ID_WIDTH-1:0]  ptr_reg;
  logic [CNT_WIDTH-1:0] inflight_reg;
  logic [CNT_WIDTH-1:0] fifo_count_reg;
  logic [PTR_WIDTH-1:0] wr_ptr_reg;
  logic [PTR_WIDTH-1:0] rd_ptr_reg;
  vec_t                 net_data_reg;
  logic                 net_valid_reg;
  logic [ID_WIDTH-1:0]  net_id_reg;
  logic                 tag_valid_reg [NET_LATENCY];
  logic [ID_WIDTH-1:0]  tag_id_reg    [NET_LATENCY];
  vec_t                 fifo_data_mem [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]  fifo_id_mem   [FIFO_DEPTH];

  logic [CNT_WIDTH:0]   outstanding;
  logic                 can_issue;
  logic                 grant_found;
  logic [ID_WIDTH-1:0]  grant_id;
  logic [ID_WIDTH-1:0]  scan_id;
  logic                 accept;
  logic                 ret_tag_valid;
  logic [ID_WIDTH-1:0]  ret_tag_id;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;

  // Every vector in the network or in the FIFO holds a FIFO slot; only the
  // registered counts are used, so a pop frees its credit one cycle later.
  assign outstanding = {1'b0, inflight_reg} + {1'b0, fifo_count_reg};
  assign can_issue   = rst_n_i && (outstanding < (CNT_WIDTH+1)'(FIFO_DEPTH));

  // Round-robin search: first valid requester starting at the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int k = 0; k < REQ_AMOUNT; k++) begin
      scan_id = ID_WIDTH'((int'(ptr_reg) + k) % REQ_AMOUNT);
      if (!grant_found && req_valid_i[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  assign accept      = can_issue && grant_found;
  assign req_ready_o = accept ? (REQ_AMOUNT'(1) << grant_id) : '0;

  // Issue stage: register the granted vector toward the network, advance the pointer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_reg       <= '0;
      net_valid_reg <= 1'b0;
      net_data_reg  <= '0;
      net_id_reg    <= '0;
    end else begin
      net_valid_reg <= accept;
      if (accept) begin
        net_data_reg <= req_data_i[grant_id];
        net_id_reg   <= grant_id;
        ptr_reg      <= (grant_id == ID_WIDTH'(REQ_AMOUNT-1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  assign net_data_o  = net_data_reg;
  assign net_valid_o = net_valid_reg;

  // Tag line: one stage per network stage, fed from the issue register so the
  // last stage lines up with net_valid_i.
  generate
    for (genvar gi = 0; gi < NET_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        // First tag stage captures what the network is sampling this cycle.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_id_reg[gi]    <= '0;
          end else begin
            tag_valid_reg[gi] <= net_valid_reg;
            tag_id_reg[gi]    <= net_id_reg;
          end
        end
      end else begin : g_body
        // Later tag stages just shift.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_id_reg[gi]    <= '0;
          end else begin
            tag_valid_reg[gi] <= tag_valid_reg[gi-1];
            tag_id_reg[gi]    <= tag_id_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign ret_tag_valid = tag_valid_reg[NET_LATENCY-1];
  assign ret_tag_id    = tag_id_reg[NET_LATENCY-1];

  // A network word without a live tag is not ours and is dropped.
  assign push       = net_valid_i && ret_tag_valid;
  assign fifo_empty = (fifo_count_reg == '0);
  assign pop        = !fifo_empty && res_ready_i;

  // Inflight counter: vectors issued to the network but not yet returned.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_reg <= '0;
    end else if (accept && !push) begin
      inflight_reg <= inflight_reg + 1'b1;
    end else if (!accept && push) begin
      inflight_reg <= inflight_reg - 1'b1;
    end
  end

  // FIFO pointers and occupancy; push/pop may coincide at any occupancy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // FIFO storage: plain write port, no reset needed since reads are gated by empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_mem[wr_ptr_reg] <= net_data_i;
      fifo_id_mem[wr_ptr_reg]   <= ret_tag_id;
    end
  end

  assign res_valid_o = !fifo_empty;
  assign res_data_o  = fifo_empty ? '0 : fifo_data_mem[rd_ptr_reg];
  assign res_id_o    = fifo_empty ? '0 : fifo_id_mem[rd_ptr_reg];

`ifdef SORT_ARBITER_CHECK_EN
  logic err_reg;

  // Sticky error: network valid disagrees with the tag line, or inflight would underflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_reg <= 1'b0;
    end else if ((net_valid_i != ret_tag_valid) ||
                 (push && !accept && (inflight_reg == '0))) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

endmodule
